axi_cmd_master: RTL and testbench



---
 rtl/axi_cmd_pkg.sv | 26 ++
 rtl/axi_cmd_fifo.sv | 54 +++++
 rtl/axi_cmd_master.sv | 190 +++++++++++++++++++
 tb/tb_axi_cmd_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cmd_pkg.sv
// Shared constants for the AXI4 register-write command master.
package axi_cmd_pkg;

    // Sequencer state encoding
    typedef logic [2:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE   = 3'd0;
    localparam fsm_state_t ST_ISSUE  = 3'd1;
    localparam fsm_state_t ST_WAIT_B = 3'd2;
    localparam fsm_state_t ST_REPORT = 3'd3;
    localparam fsm_state_t ST_FAULT  = 3'd4;

    // AXI encodings
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Timestamp-controller register map
    localparam logic [5:0] CMD_REG_ADDR    = 6'h00;
    localparam logic [5:0] OFFSET_REG_ADDR = 6'h10;

    // Saturating increment for the error counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi_cmd_fifo.sv
// Small synchronous FIFO holding {addr, data} write commands.
module axi_cmd_fifo
#(
    parameter int unsigned WIDTH = 134,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

    // Advance pointers on accepted push/pop
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Pointer registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/axi_cmd_master.sv
// Turns queued register-write commands into single-beat AXI4 write bursts,
// one outstanding transaction at a time, and reports each write response.
module axi_cmd_master
    import axi_cmd_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH   = 6,
    parameter int unsigned AXI_DATA_WIDTH   = 128,
    parameter int unsigned AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
    parameter int unsigned AXI_STROBE_LEN   = 4,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 1024,
    parameter logic [15:0] AXI_ID           = 16'h0
) (
    input  logic                        m_axi_aclk,
    input  logic                        m_axi_aresetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_data,
    output logic                        resp_valid,
    output logic [1:0]                  resp_bresp,
    output logic                        resp_timeout,
    output logic                        busy,
    output logic [15:0]                 err_count,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [15:0]                 m_axi_awid,
    output logic [15:0]                 m_axi_awuser,
    output logic [1:0]                  m_axi_awburst,
    output logic [2:0]                  m_axi_awsize,
    output logic [7:0]                  m_axi_awlen,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_STROBE_WIDTH-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    output logic                        m_axi_wlast,
    input  logic                        m_axi_wready,
    input  logic                        m_axi_bvalid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic [15:0]                 m_axi_bid,
    output logic                        m_axi_bready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fsm_state_t                state_q, state_d;
    logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [1:0]                resp_bresp_q, resp_bresp_d;
    logic                      resp_timeout_q, resp_timeout_d;
    logic [15:0]               err_count_q, err_count_d;

    logic                      fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [AXI_ADDR_WIDTH-1:0] fifo_addr;
    logic [AXI_DATA_WIDTH-1:0] fifo_data;
    logic                      aw_hs, w_hs, b_hs;

    assign cmd_ready = !fifo_full && (state_q != ST_FAULT);
    assign fifo_push = cmd_valid && cmd_ready;

    axi_cmd_fifo #(
        .WIDTH (AXI_ADDR_WIDTH + AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (m_axi_aclk),
        .rst_ni      (m_axi_aresetn),
        .push_i      (fifo_push),
        .push_data_i ({cmd_addr, cmd_data}),
        .pop_i       (fifo_pop),
        .pop_data_o  ({fifo_addr, fifo_data}),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign aw_hs = awvalid_q && m_axi_awready;
    assign w_hs  = wvalid_q && m_axi_wready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;

    // Fixed burst fields are gated by their valid so every output idles at 0
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awuser  = '0;
    assign m_axi_awlen   = '0;
    assign m_axi_awburst = awvalid_q ? AXI_BURST_INCR : '0;
    assign m_axi_awsize  = awvalid_q ? 3'(AXI_STROBE_LEN) : '0;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wvalid_q ? '1 : '0;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wlast   = wvalid_q;
    assign m_axi_bready  = (state_q == ST_WAIT_B) || (state_q == ST_FAULT);

    assign resp_valid    = resp_valid_q;
    assign resp_bresp    = resp_bresp_q;
    assign resp_timeout  = resp_timeout_q;
    assign err_count     = err_count_q;
    assign busy          = !fifo_empty || (state_q != ST_IDLE);

    // Sequencer next state, channel valids, timeout and completion reporting
    always_comb begin
        state_d        = state_q;
        awvalid_d      = awvalid_q && !aw_hs;
        wvalid_d       = wvalid_q && !w_hs;
        awaddr_d       = awaddr_q;
        wdata_d        = wdata_q;
        tmo_cnt_d      = tmo_cnt_q;
        resp_valid_d   = 1'b0;
        resp_bresp_d   = resp_bresp_q;
        resp_timeout_d = resp_timeout_q;
        fifo_pop       = 1'b0;
        err_count_d    = err_count_q;
        if (resp_valid_q && (resp_bresp_q != AXI_RESP_OKAY)) begin
            err_count_d = sat_inc16(err_count_q);
        end
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    awaddr_d  = fifo_addr;
                    wdata_d   = fifo_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_cnt_q == CNT_LAST) begin
                    state_d        = ST_FAULT;
                    resp_valid_d   = 1'b1;
                    resp_bresp_d   = AXI_RESP_SLVERR;
                    resp_timeout_d = 1'b1;
                end else if (!awvalid_d && !wvalid_d) begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A B beat arriving on the timeout cycle still counts as a completion
                if (b_hs) begin
                    state_d        = ST_REPORT;
                    resp_valid_d   = 1'b1;
                    resp_bresp_d   = (m_axi_bid != AXI_ID) ? AXI_RESP_SLVERR : m_axi_bresp;
                    resp_timeout_d = 1'b0;
                end else if (tmo_cnt_q == CNT_LAST) begin
                    state_d        = ST_FAULT;
                    resp_valid_d   = 1'b1;
                    resp_bresp_d   = AXI_RESP_SLVERR;
                    resp_timeout_d = 1'b1;
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer and output registers, cleared asynchronously
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q        <= ST_IDLE;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            tmo_cnt_q      <= '0;
            resp_valid_q   <= 1'b0;
            resp_bresp_q   <= '0;
            resp_timeout_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            awaddr_q       <= awaddr_d;
            wdata_q        <= wdata_d;
            tmo_cnt_q      <= tmo_cnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_bresp_q   <= resp_bresp_d;
            resp_timeout_q <= resp_timeout_d;
            err_count_q    <= err_count_d;
        end
    end

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed bench for axi_cmd_master with a small scripted AXI slave.
module tb_axi_cmd_master;
    import axi_cmd_pkg::*;

    localparam int unsigned TO = 64;

    logic         clk, rst_n;
    logic         cmd_valid, cmd_ready;
    logic [5:0]   cmd_addr;
    logic [127:0] cmd_data;
    logic         resp_valid, resp_timeout, busy;
    logic [1:0]   resp_bresp;
    logic [15:0]  err_count;
    logic [5:0]   awaddr;
    logic [15:0]  awid, awuser;
    logic [1:0]   awburst;
    logic [2:0]   awsize;
    logic [7:0]   awlen;
    logic         awvalid, awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wvalid, wlast, wready;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic [15:0]  bid;

    axi_cmd_master #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .resp_valid    (resp_valid),
        .resp_bresp    (resp_bresp),
        .resp_timeout  (resp_timeout),
        .busy          (busy),
        .err_count     (err_count),
        .m_axi_awaddr  (awaddr),
        .m_axi_awid    (awid),
        .m_axi_awuser  (awuser),
        .m_axi_awburst (awburst),
        .m_axi_awsize  (awsize),
        .m_axi_awlen   (awlen),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wlast   (wlast),
        .m_axi_wready  (wready),
        .m_axi_bvalid  (bvalid),
        .m_axi_bresp   (bresp),
        .m_axi_bid     (bid),
        .m_axi_bready  (bready)
    );

    int errors = 0;
    int checks = 0;

    // slave configuration and bookkeeping
    logic         awready_cfg = 1'b1;
    logic         seq_mode    = 1'b0;
    logic         b_enable    = 1'b1;
    logic [1:0]   b_resp_cfg  = 2'b00;
    logic [15:0]  b_id_cfg    = 16'h0;
    int           aw_hs_cnt   = 0;
    int           w_hs_cnt    = 0;
    int           b_sent      = 0;
    int           cyc         = 0;
    int           last_aw_cyc = 0;
    int           last_w_cyc  = 0;
    logic [5:0]   sent_addr [$];
    logic [127:0] sent_data [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input string tag, input logic [5:0] a, input logic [127:0] d);
        logic accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (cmd_ready) begin
                accepted = 1'b1;
                sent_addr.push_back(a);
                sent_data.push_back(d);
            end
            tick();
        end
        cmd_valid = 1'b0;
        check_eq({tag, "_accept"}, 128'(accepted), 128'(1));
    endtask

    task automatic wait_resp(input string tag, input logic [1:0] exp_bresp, input logic exp_to,
                             output int n);
        n = 0;
        while (!resp_valid && n < 400) begin
            tick();
            n++;
        end
        check_eq({tag, "_seen"}, 128'(resp_valid), 128'(1));
        check_eq({tag, "_bresp"}, 128'(resp_bresp), 128'(exp_bresp));
        check_eq({tag, "_timeout"}, 128'(resp_timeout), 128'(exp_to));
        tick();
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Channel monitor: negedge values equal what the next posedge samples
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (awvalid) begin
                    if (aw_hs_cnt < sent_addr.size())
                        check_eq("aw_addr", 128'(awaddr), 128'(sent_addr[aw_hs_cnt]));
                    else
                        check_eq("aw_unexpected", 128'(awvalid), 128'(0));
                end
                if (wvalid) begin
                    if (w_hs_cnt < sent_data.size())
                        check_eq("w_data", wdata, sent_data[w_hs_cnt]);
                    else
                        check_eq("w_unexpected", 128'(wvalid), 128'(0));
                end
                if (awvalid && awready) begin
                    check_eq("aw_len", 128'(awlen), 128'(0));
                    check_eq("aw_size", 128'(awsize), 128'(4));
                    check_eq("aw_burst", 128'(awburst), 128'(1));
                    aw_hs_cnt++;
                    last_aw_cyc = cyc;
                end
                if (wvalid && wready) begin
                    check_eq("w_strb", 128'(wstrb), 128'(16'hFFFF));
                    check_eq("w_last", 128'(wlast), 128'(1));
                    w_hs_cnt++;
                    last_w_cyc = cyc;
                end
            end
        end
    end

    // Slave: B beat is a single-cycle pulse once both AW and W are accepted
    initial begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        bid     = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            bvalid  = 1'b0;
            awready = awready_cfg;
            wready  = seq_mode ? (aw_hs_cnt > w_hs_cnt) : 1'b1;
            if (rst_n && b_enable && aw_hs_cnt > b_sent && w_hs_cnt > b_sent &&
                (!seq_mode || bready)) begin
                check_eq("bready_before_bvalid", 128'(bready), 128'(1));
                bvalid = 1'b1;
                bresp  = b_resp_cfg;
                bid    = b_id_cfg;
                b_sent++;
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        #2;
        // reset values
        check_eq("rst_awvalid", 128'(awvalid), 128'(0));
        check_eq("rst_wvalid", 128'(wvalid), 128'(0));
        check_eq("rst_bready", 128'(bready), 128'(0));
        check_eq("rst_resp_valid", 128'(resp_valid), 128'(0));
        check_eq("rst_resp_bresp", 128'(resp_bresp), 128'(0));
        check_eq("rst_resp_timeout", 128'(resp_timeout), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_err_count", 128'(err_count), 128'(0));
        check_eq("rst_awaddr", 128'(awaddr), 128'(0));
        check_eq("rst_wdata", wdata, 128'(0));
        check_eq("rst_awid", 128'(awid), 128'(0));
        check_eq("rst_awuser", 128'(awuser), 128'(0));
        check_eq("rst_awburst", 128'(awburst), 128'(0));
        check_eq("rst_wlast", 128'(wlast), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // single write, always-ready slave, cycle-exact
        cmd_valid = 1'b1;
        cmd_addr  = CMD_REG_ADDR;
        cmd_data  = 128'h5;
        check_eq("t1_cmd_ready", 128'(cmd_ready), 128'(1));
        sent_addr.push_back(CMD_REG_ADDR);
        sent_data.push_back(128'h5);
        tick();                                  // edge N: push
        cmd_valid = 1'b0;
        check_eq("t1_busy_n", 128'(busy), 128'(1));
        check_eq("t1_awvalid_n", 128'(awvalid), 128'(0));
        tick();                                  // edge N+1: pop, issue
        check_eq("t1_awvalid", 128'(awvalid), 128'(1));
        check_eq("t1_wvalid", 128'(wvalid), 128'(1));
        check_eq("t1_awaddr", 128'(awaddr), 128'(0));
        check_eq("t1_awlen", 128'(awlen), 128'(0));
        check_eq("t1_awsize", 128'(awsize), 128'(4));
        check_eq("t1_wdata", wdata, 128'h5);
        check_eq("t1_wstrb", 128'(wstrb), 128'(16'hFFFF));
        check_eq("t1_wlast", 128'(wlast), 128'(1));
        check_eq("t1_bready_issue", 128'(bready), 128'(0));
        tick();                                  // edge N+2: AW/W handshake
        check_eq("t1_awvalid_drop", 128'(awvalid), 128'(0));
        check_eq("t1_wvalid_drop", 128'(wvalid), 128'(0));
        check_eq("t1_bready", 128'(bready), 128'(1));
        check_eq("t1_no_resp_yet", 128'(resp_valid), 128'(0));
        tick();                                  // edge N+3: B handshake
        check_eq("t1_resp_valid", 128'(resp_valid), 128'(1));
        check_eq("t1_resp_bresp", 128'(resp_bresp), 128'(0));
        check_eq("t1_resp_timeout", 128'(resp_timeout), 128'(0));
        tick();
        check_eq("t1_resp_pulse", 128'(resp_valid), 128'(0));
        check_eq("t1_err_count", 128'(err_count), 128'(0));
        check_eq("t1_busy_done", 128'(busy), 128'(0));

        // sequential slave: W only after AW, B only while bready
        seq_mode = 1'b1;
        tick();
        send_cmd("seq", OFFSET_REG_ADDR, 128'h1234);
        wait_resp("seq", 2'b00, 1'b0, n);
        check_eq("seq_w_after_aw", 128'(last_w_cyc > last_aw_cyc), 128'(1));
        seq_mode = 1'b0;
        tick();

        // back-pressure: AW stalled, 5 accepted then cmd_ready low
        awready_cfg = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            send_cmd("bp", 6'(4 * i), 128'(32'hA000 + i));
        end
        cmd_valid = 1'b1;
        cmd_addr  = 6'h3C;
        cmd_data  = 128'hDEAD;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_full_ready", 128'(cmd_ready), 128'(0));
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("bp_busy", 128'(busy), 128'(1));
        check_eq("bp_stalled_awvalid", 128'(awvalid), 128'(1));
        awready_cfg = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_resp("bp", 2'b00, 1'b0, n);
        end
        tick();
        check_eq("bp_aw_count", 128'(aw_hs_cnt), 128'(sent_addr.size()));
        check_eq("bp_w_count", 128'(w_hs_cnt), 128'(sent_data.size()));
        check_eq("bp_idle", 128'(busy), 128'(0));
        check_eq("bp_err_count", 128'(err_count), 128'(0));

        // error responses: SLVERR, then OKAY with the wrong ID
        b_resp_cfg = 2'b10;
        send_cmd("err1", 6'h08, 128'h11);
        wait_resp("err1", 2'b10, 1'b0, n);
        b_resp_cfg = 2'b00;
        b_id_cfg   = 16'h7;
        send_cmd("err2", 6'h0C, 128'h22);
        wait_resp("err2", 2'b10, 1'b0, n);
        check_eq("err_count2", 128'(err_count), 128'(2));
        b_id_cfg = 16'h0;

        // timeout: no B beat ever arrives
        b_enable = 1'b0;
        send_cmd("to", 6'h00, 128'h33);
        tick();                                  // ISSUE entry edge
        check_eq("to_issue", 128'(awvalid), 128'(1));
        wait_resp("to", 2'b10, 1'b1, n);
        check_eq("to_latency", 128'(n), 128'(TO));
        check_eq("to_pulse", 128'(resp_valid), 128'(0));
        check_eq("to_err_count", 128'(err_count), 128'(3));
        check_eq("to_cmd_ready", 128'(cmd_ready), 128'(0));
        check_eq("to_busy", 128'(busy), 128'(1));
        repeat (10) tick();
        check_eq("to_cmd_ready_hold", 128'(cmd_ready), 128'(0));
        check_eq("to_busy_hold", 128'(busy), 128'(1));
        check_eq("to_no_second_resp", 128'(resp_valid), 128'(0));

        // clear the fault
        rst_n = 1'b0;
        sent_addr.delete();
        sent_data.delete();
        aw_hs_cnt = 0;
        w_hs_cnt  = 0;
        b_sent    = 0;
        b_enable  = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("clr_err_count", 128'(err_count), 128'(0));
        check_eq("clr_cmd_ready", 128'(cmd_ready), 128'(1));

        // reset mid-transaction with a second command queued
        awready_cfg = 1'b0;
        tick();
        send_cmd("mid_a", 6'h04, 128'hAA);
        send_cmd("mid_b", 6'h08, 128'hBB);
        check_eq("mid_awvalid_pre", 128'(awvalid), 128'(1));
        check_eq("mid_wvalid_pre", 128'(wvalid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_awvalid", 128'(awvalid), 128'(0));
        check_eq("mid_wvalid", 128'(wvalid), 128'(0));
        check_eq("mid_bready", 128'(bready), 128'(0));
        check_eq("mid_busy", 128'(busy), 128'(0));
        sent_addr.delete();
        sent_data.delete();
        aw_hs_cnt = 0;
        w_hs_cnt  = 0;
        b_sent    = 0;
        awready_cfg = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send_cmd("post", OFFSET_REG_ADDR, 128'h77);
        wait_resp("post", 2'b00, 1'b0, n);
        repeat (5) tick();
        check_eq("post_aw_count", 128'(aw_hs_cnt), 128'(1));
        check_eq("post_busy", 128'(busy), 128'(0));
        check_eq("post_err_count", 128'(err_count), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
